// File: rtl/spis_cpu_pkg.sv
// Shared definitions for the SPIS accumulator CPU: opcode map, FSM states
// and small opcode-class helpers used by the core and the ALU.
package spis_cpu_pkg;

  // Opcodes live in the high nibble of instruction word 0.
  localparam logic [3:0] OP_ADD = 4'h0;  // A += B
  localparam logic [3:0] OP_SUB = 4'h1;  // A -= B
  localparam logic [3:0] OP_ADC = 4'h2;  // A += B + carry
  localparam logic [3:0] OP_SBC = 4'h3;  // A = A - B - !carry
  localparam logic [3:0] OP_SWB = 4'h4;  // swap A,B
  localparam logic [3:0] OP_LDI = 4'h5;  // A = word1
  localparam logic [3:0] OP_LD  = 4'h6;  // A = [addr]
  localparam logic [3:0] OP_LDX = 4'h7;  // A = [addr + C]
  localparam logic [3:0] OP_ST  = 4'h8;  // [addr] = A
  localparam logic [3:0] OP_STX = 4'h9;  // [addr + C] = A
  localparam logic [3:0] OP_SWC = 4'hA;  // swap A,C
  localparam logic [3:0] OP_JEQ = 4'hB;  // if A == B jump addr
  localparam logic [3:0] OP_JMP = 4'hC;  // jump addr
  localparam logic [3:0] OP_NOT = 4'hD;  // A = ~A
  localparam logic [3:0] OP_AND = 4'hE;  // A &= B
  localparam logic [3:0] OP_OR  = 4'hF;  // A |= B

  // Core sequencing states. The state register is a plain named signal
  // (state_q) inside the core so checkers can bind to it directly.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    OPER  = 2'd1,
    EXEC  = 2'd2,
    MEM   = 2'd3
  } state_t;

  // Opcodes that carry a second instruction word (address or immediate).
  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      OP_LDI, OP_LD, OP_LDX, OP_ST, OP_STX, OP_JEQ, OP_JMP: has_operand = 1'b1;
      default:                                              has_operand = 1'b0;
    endcase
  endfunction

  // Opcodes that update the carry flag.
  function automatic logic is_arith(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: is_arith = 1'b1;
      default:                        is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spis_alu.sv
// Combinational ALU for the EXEC-class opcodes. Subtraction is done as
// A + ~B + carry-in, so the carry-out is the inverted borrow.
module spis_alu
  import spis_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              zero
);

  localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] nb_x;
  logic [DATA_W:0] cin_x;
  logic [DATA_W:0] sum;

  assign a_x   = {1'b0, a};
  assign b_x   = {1'b0, b};
  assign nb_x  = {1'b0, ~b};
  assign cin_x = {{DATA_W{1'b0}}, cin};

  // Opcode select: arithmetic goes through one DATA_W+1 adder, logic ops bypass it.
  always_comb begin
    sum    = '0;
    result = a;
    cout   = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = a_x + b_x;
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_SUB: begin
        sum    = a_x + nb_x + ONE;
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_ADC: begin
        sum    = a_x + b_x + cin_x;
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_SBC: begin
        sum    = a_x + nb_x + cin_x;
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_NOT:  result = ~a;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = a;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/spis_cpu_core.sv
// SPIS accumulator CPU core: FETCH/OPER/EXEC/MEM sequencer, instruction
// pointer, A/B/C registers, carry/zero flags and bus output decode.
//
// Bus handshake: in FETCH, OPER and MEM exactly one of memRead/memWrite is
// high and memAddr/dataOut/sync are held constant until a rising edge with
// memReady=1 completes the cycle; dataIn is sampled on that edge. An edge with
// memReady=0 is a wait cycle and changes no state. EXEC issues no bus cycle.
module spis_cpu_core
  import spis_cpu_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int RESET_VEC = 0
) (
  input  logic              clock,
  input  logic              resetN,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRead,
  output logic              memWrite,
  input  logic              memReady,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              sync,
  output logic              flagC,
  output logic              flagZ
);

  if (DATA_W < 8) begin : g_bad_data_w
    $error("spis_cpu_core: DATA_W must be at least 8");
  end
  if (ADDR_W > 2 * DATA_W - 4) begin : g_bad_addr_w
    $error("spis_cpu_core: ADDR_W must not exceed 2*DATA_W-4");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] ip_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] w0_q;
  logic [DATA_W-1:0] w1_q;
  logic [DATA_W-1:0] dout_q;
  logic              fc_q;
  logic              fz_q;

  logic [3:0]        op_q;
  logic [3:0]        op_in;
  logic              indexed;
  logic              is_store;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] data_addr;

  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              alu_zero;

  // Opcode of the instruction in flight, and of the word arriving in FETCH.
  assign op_q  = w0_q[DATA_W-1 -: 4];
  assign op_in = dataIn[DATA_W-1 -: 4];

  assign indexed  = (op_q == OP_LDX) || (op_q == OP_STX);
  assign is_store = (op_q == OP_ST)  || (op_q == OP_STX);

  // Jump targets use word1 straight off the bus; data accesses use the latched copy.
  assign jump_addr = ADDR_W'({w0_q[DATA_W-5:0], dataIn});
  assign base_addr = ADDR_W'({w0_q[DATA_W-5:0], w1_q});
  assign data_addr = indexed ? (base_addr + ADDR_W'(c_q)) : base_addr;

  spis_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .cin    (fc_q),
    .result (alu_result),
    .cout   (alu_cout),
    .zero   (alu_zero)
  );

  // Bus outputs decode purely from state and registers; all forced low in reset.
  always_comb begin
    memAddr  = '0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    sync     = 1'b0;
    dataOut  = '0;
    if (resetN) begin
      case (state_q)
        FETCH: begin
          memRead = 1'b1;
          sync    = 1'b1;
          memAddr = ip_q;
        end
        OPER: begin
          memRead = 1'b1;
          memAddr = ip_q;
        end
        MEM: begin
          memAddr = data_addr;
          if (is_store) begin
            memWrite = 1'b1;
            dataOut  = dout_q;
          end else begin
            memRead = 1'b1;
          end
        end
        default: begin
          memAddr = '0;
        end
      endcase
    end
  end

  assign flagC = fc_q;
  assign flagZ = fz_q;

  // Sequencer and architectural state; bus states advance only on memReady.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= FETCH;
      ip_q    <= ADDR_W'(RESET_VEC);
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      dout_q  <= '0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (memReady) begin
            w0_q    <= dataIn;
            ip_q    <= ip_q + ADDR_W'(1);
            state_q <= has_operand(op_in) ? OPER : EXEC;
          end
        end
        OPER: begin
          if (memReady) begin
            w1_q    <= dataIn;
            ip_q    <= ip_q + ADDR_W'(1);
            state_q <= FETCH;
            case (op_q)
              OP_LDI: a_q <= dataIn;
              OP_JEQ: if (a_q == b_q) ip_q <= jump_addr;
              OP_JMP: ip_q <= jump_addr;
              default: begin
                dout_q  <= a_q;
                state_q <= MEM;
              end
            endcase
          end
        end
        EXEC: begin
          state_q <= FETCH;
          case (op_q)
            OP_SWB: begin
              a_q <= b_q;
              b_q <= a_q;
            end
            OP_SWC: begin
              a_q <= c_q;
              c_q <= a_q;
            end
            default: begin
              a_q  <= alu_result;
              fz_q <= alu_zero;
              if (is_arith(op_q)) fc_q <= alu_cout;
            end
          endcase
        end
        MEM: begin
          if (memReady) begin
            if (!is_store) a_q <= dataIn;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_spis_cpu_core.sv
// Bench for spis_cpu_core (DATA_W=8, ADDR_W=12, RESET_VEC=0).
// An instruction-level model predicts the bus transactions of each
// instruction and the flags seen at the following fetch.
module tb_spis_cpu_core;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int TW = 23;   // {kind[1:0], sync, addr[11:0], data[7:0]}

  // ---------------- clock / reset ----------------
  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          memReady = 1'b0;
  logic [AW-1:0] memAddr;
  logic          memRead;
  logic          memWrite;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] dataOut;
  logic          sync;
  logic          flagC;
  logic          flagZ;

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:4095];   // bus-side memory, written by the DUT
  logic [DW-1:0] mm  [0:4095];   // model's own memory image

  assign dataIn = mem[memAddr];

  spis_cpu_core #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .RESET_VEC (0)
  ) dut (
    .clock    (clock),
    .resetN   (resetN),
    .memAddr  (memAddr),
    .memRead  (memRead),
    .memWrite (memWrite),
    .memReady (memReady),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .sync     (sync),
    .flagC    (flagC),
    .flagZ    (flagZ)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [TW-1:0] exp_q[$];

  logic [AW-1:0] m_ip;
  logic [DW-1:0] m_a, m_b, m_c;
  logic          m_fc, m_fz;

  bit            monitor_en = 1'b0;
  int            n_instr = 0;
  int            cyc = 0;
  int            wr_cycles = 0;
  int            ready_pct = 100;   // <0 selects three wait cycles per access
  int            wcnt = 0;
  logic [TW-1:0] snap;
  logic [AW-1:0] fetch_addr  [0:511];
  int            fetch_cyc   [0:511];
  logic [1:0]    fetch_flags [0:511];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [TW-1:0] pack(input logic [1:0] k, input logic s,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {k, s, a, d};
  endfunction

  function automatic logic [TW-1:0] outs();
    return {memRead, memWrite, sync, memAddr, dataOut};
  endfunction

  // ---------------- reference model ----------------
  // Executes one whole instruction from the model's memory image and queues
  // the bus transactions it implies (kind 1 = read, 2 = write).
  task automatic model_step();
    logic [DW-1:0] w0, w1;
    logic [AW-1:0] ea;
    int s;
    w0 = mm[m_ip];
    exp_q.push_back(pack(2'd1, 1'b1, m_ip, 8'h00));
    m_ip = m_ip + 1;
    case (w0[7:4])
      4'h0: begin s = m_a + m_b;            m_fc = (s > 255); m_a = s[7:0]; m_fz = (m_a == 0); end
      4'h1: begin s = m_a - m_b;            m_fc = (s >= 0);  m_a = s[7:0]; m_fz = (m_a == 0); end
      4'h2: begin s = m_a + m_b + m_fc;     m_fc = (s > 255); m_a = s[7:0]; m_fz = (m_a == 0); end
      4'h3: begin s = m_a - m_b - (m_fc ? 0 : 1); m_fc = (s >= 0); m_a = s[7:0]; m_fz = (m_a == 0); end
      4'h4: begin {m_a, m_b} = {m_b, m_a}; end
      4'hA: begin {m_a, m_c} = {m_c, m_a}; end
      4'hD: begin m_a = ~m_a;       m_fz = (m_a == 0); end
      4'hE: begin m_a = m_a & m_b;  m_fz = (m_a == 0); end
      4'hF: begin m_a = m_a | m_b;  m_fz = (m_a == 0); end
      default: begin
        w1 = mm[m_ip];
        exp_q.push_back(pack(2'd1, 1'b0, m_ip, 8'h00));
        m_ip = m_ip + 1;
        ea = {w0[3:0], w1};
        if (w0[7:4] == 4'h7 || w0[7:4] == 4'h9) ea = (ea + m_c) % 4096;
        case (w0[7:4])
          4'h5: m_a = w1;
          4'hB: if (m_a == m_b) m_ip = {w0[3:0], w1};
          4'hC: m_ip = {w0[3:0], w1};
          4'h6, 4'h7: begin
            exp_q.push_back(pack(2'd1, 1'b0, ea, 8'h00));
            m_a = mm[ea];
          end
          default: begin
            exp_q.push_back(pack(2'd2, 1'b0, ea, m_a));
            mm[ea] = m_a;
          end
        endcase
      end
    endcase
  endtask

  // ---------------- monitor / driver ----------------
  // Called at a negedge for a bus cycle that completes on the next posedge.
  task automatic observe();
    logic [TW-1:0] got, exp;
    if (sync) begin
      if (n_instr < 512) begin
        fetch_addr[n_instr]  = memAddr;
        fetch_cyc[n_instr]   = cyc;
        fetch_flags[n_instr] = {flagC, flagZ};
      end
      check("flags_at_fetch", {flagC, flagZ}, {m_fc, m_fz});
      check("queue_empty_at_fetch", exp_q.size(), 0);
      exp_q.delete();
      model_step();
      n_instr++;
    end
    got = pack(memWrite ? 2'd2 : 2'd1, sync, memAddr, memWrite ? dataOut : 8'h00);
    if (exp_q.size() == 0) check("unexpected_bus_cycle", got, 0);
    else begin
      exp = exp_q.pop_front();
      check(memWrite ? "bus_write" : "bus_read", got, exp);
    end
    check("rd_wr_exclusive", memRead & memWrite, 0);
    if (memWrite) mem[memAddr] = dataOut;
  endtask

  // Runs at a negedge: choose memReady, score the cycle, advance one clock.
  task automatic bus_cycle();
    if (memWrite) wr_cycles++;
    if (ready_pct < 0) begin
      if (memRead || memWrite) begin
        if (wcnt == 0) snap = outs();
        else check("hold_during_wait", outs(), snap);
        memReady = (wcnt == 3);
        wcnt = memReady ? 0 : wcnt + 1;
      end else begin
        memReady = 1'b0;
        wcnt = 0;
      end
    end else begin
      memReady = ($urandom_range(99) < ready_pct);
    end
    if (monitor_en && memReady && (memRead || memWrite)) observe();
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    monitor_en = 1'b0;
    resetN = 1'b0;
    memReady = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("outputs_in_reset", outs(), 0);
    end
    exp_q.delete();
    for (int i = 0; i < 4096; i++) mm[i] = mem[i];
    m_ip = '0; m_a = '0; m_b = '0; m_c = '0; m_fc = 1'b0; m_fz = 1'b0;
    n_instr = 0; cyc = 0; wr_cycles = 0; wcnt = 0;
    resetN = 1'b1;
    @(negedge clock);
    check("release_read", memRead, 1);
    check("release_sync", sync, 1);
    check("release_write", memWrite, 0);
    check("release_addr", memAddr, 0);
    monitor_en = 1'b1;
  endtask

  task automatic run_instrs(input int target, input int pct);
    int guard;
    guard = 0;
    ready_pct = pct;
    while (n_instr < target && guard < 20000) begin
      bus_cycle();
      guard++;
    end
    check("instr_count_in_budget", n_instr, target);
  endtask

  task automatic load_prog(input logic [127:0] v, input int n);
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < n; i++) mem[i] = v[8*(n-1-i) +: 8];
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    // Register chain ending in ADD with carry out and zero result.
    load_prog(128'h51_05_A0_51_FB_40_51_05_00_81_00, 11);
    mem[12'h100] = 8'hEE;
    do_reset();
    run_instrs(8, 100);
    check("rom_a_stored", mem[12'h100], 8'h00);
    check("rom_flags_cz", fetch_flags[7], 2'b11);
    check("lat_ldi", fetch_cyc[1] - fetch_cyc[0], 2);
    check("lat_swap", fetch_cyc[2] - fetch_cyc[1], 2);
    check("lat_add", fetch_cyc[6] - fetch_cyc[5], 2);
    check("lat_st", fetch_cyc[7] - fetch_cyc[6], 3);

    // SBC with carry clear, then SUB with borrow.
    load_prog(128'h51_01_40_51_10_30_81_01_51_02_40_51_01_10_81_02, 16);
    do_reset();
    run_instrs(11, 100);
    check("sbc_result", mem[12'h101], 8'h0E);
    check("sbc_flags", fetch_flags[4], 2'b10);
    check("sub_result", mem[12'h102], 8'hFF);
    check("sub_flags", fetch_flags[9], 2'b00);

    // Indexed store wrapping the 12-bit address space.
    load_prog(128'h51_10_A0_51_5A_9F_F8, 7);
    mem[12'h008] = 8'hEE;
    do_reset();
    run_instrs(5, 100);
    check("stx_wrap_data", mem[12'h008], 8'h5A);
    check("stx_write_cycles", wr_cycles, 1);

    // Three wait cycles on every access of LD 0x123, then store A.
    load_prog(128'h61_23_81_00, 4);
    mem[12'h123] = 8'h3C;
    mem[12'h100] = 8'hEE;
    do_reset();
    run_instrs(3, -1);
    check("ld_wait_total", fetch_cyc[1] - fetch_cyc[0], 12);
    check("ld_wait_value", mem[12'h100], 8'h3C);

    // JEQ taken (A == B == 0) and not taken.
    load_prog(128'hBA_BC, 2);
    do_reset();
    run_instrs(2, 100);
    check("jeq_taken_addr", fetch_addr[1], 12'hABC);
    load_prog(128'h51_01_BA_BC, 4);
    do_reset();
    run_instrs(3, 100);
    check("jeq_fallthrough_addr", fetch_addr[2], 12'h004);

    // IP wrap: operand of an LDI at 0xFFF is read from 0x000.
    load_prog(128'hCF_FE, 2);
    mem[12'hFFE] = 8'h40;
    mem[12'hFFF] = 8'h50;
    do_reset();
    run_instrs(4, 100);
    check("jmp_target", fetch_addr[1], 12'hFFE);
    check("wrap_next_fetch", fetch_addr[3], 12'h001);

    // Reset during the MEM cycle of a store aborts it.
    load_prog(128'h50_77_81_00, 4);
    mem[12'h100] = 8'hEE;
    do_reset();
    ready_pct = 100;
    for (int g = 0; g < 50 && !memWrite; g++) bus_cycle();
    check("abort_reached_store", memWrite, 1);
    do_reset();
    check("abort_no_write", mem[12'h100], 8'hEE);
    run_instrs(3, 100);
    check("abort_rerun_write", mem[12'h100], 8'h77);
    check("abort_rerun_cycles", wr_cycles, 1);

    // Random memory images executed under varying bus readiness.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(255));
      do_reset();
      run_instrs(250, (r == 0) ? 100 : (r == 1) ? 70 : 40);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
